// File: rtl/full_use_half_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : full_use_half_subtractor_pkg
// Brief    : Shared constants for the ripple-borrow subtractor cell.
// Revision : 1.0 - initial release
// ============================================================================
package full_use_half_subtractor_pkg;

    // Value both registered outputs take while reset is asserted.
    localparam logic c_RST_VAL = 1'b0;

    typedef struct packed {
        logic diff;
        logic borrow;
    } sub_result_t;

endpackage
`default_nettype wire

// File: rtl/full_use_half_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : full_use_half_subtractor_if
// Brief    : Operand and result bundle for one full-subtractor cell.
// Revision : 1.0 - initial release
// ============================================================================
interface full_use_half_subtractor_if;
    logic a;
    logic b;
    logic c;
    logic diff;
    logic borrow;

    modport master (
        output a,
        output b,
        output c,
        input  diff,
        input  borrow
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output diff,
        output borrow
    );
endinterface
`default_nettype wire

// File: rtl/full_use_half_subtractor_half_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : half_subtractor
// Brief    : Combinational x - y producing difference and borrow-out.
// Revision : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  wire logic x,
    input  wire logic y,
    output logic      d,
    output logic      bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule
`default_nettype wire

// File: rtl/full_use_half_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_use_half_subtractor
// Brief    : Registered a - b - c from two cascaded half subtractors.
// Revision : 1.0 - initial release
// ============================================================================
module full_use_half_subtractor
    import full_use_half_subtractor_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    full_use_half_subtractor_if.slave bus
);

    logic w_d1;
    logic w_b1;
    logic w_d2;
    logic w_b2;
    logic r_diff;
    logic r_borrow;

    half_subtractor u_hs1 (
        .x  (bus.a),
        .y  (bus.b),
        .d  (w_d1),
        .bo (w_b1)
    );

    half_subtractor u_hs2 (
        .x  (w_d1),
        .y  (bus.c),
        .d  (w_d2),
        .bo (w_b2)
    );

    // Plain gates throughout so unknowns propagate with gate-level semantics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= c_RST_VAL;
            r_borrow <= c_RST_VAL;
        end else begin
            r_diff   <= w_d2;
            r_borrow <= w_b1 | w_b2;
        end
    end

    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_full_use_half_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_use_half_subtractor
// Brief    : Self-checking bench for the registered full-subtractor cell.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_use_half_subtractor;

    logic clk = 1'b0;
    logic rst;
    logic hx;
    logic hy;
    logic hd;
    logic hbo;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    full_use_half_subtractor_if bus ();

    full_use_half_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    half_subtractor u_hs (
        .x  (hx),
        .y  (hy),
        .d  (hd),
        .bo (hbo)
    );

    // Reference: integer subtraction for known inputs, required table for unknowns.
    function automatic logic [1:0] ref_model(input logic a, input logic b, input logic c);
        int r;
        if ($isunknown({a, b, c})) begin
            if (a === 1'bx && b === 1'b0 && c === 1'b0)
                return 2'bx0;
            return 2'bxx;
        end
        r = int'(a) - int'(b) - int'(c);
        return {r[0], r < 0};
    endfunction

    task automatic step(input logic a, input logic b, input logic c, input logic r);
        bus.a = a;
        bus.b = b;
        bus.c = c;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] exp);
        total++;
        if ({bus.diff, bus.borrow} !== exp) begin
            bad++;
            $display("FAIL %s: got diff,borrow=%b%b required %b%b",
                     name, bus.diff, bus.borrow, exp[1], exp[0]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            check("reset_hold", 2'b00);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_release", ref_model(1'b1, 1'b1, 1'b1));
    endtask

    task automatic test_sweep();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(v[2], v[1], v[0], 1'b0);
            check($sformatf("sweep_%b", v), ref_model(v[2], v[1], v[0]));
        end
    endtask

    task automatic test_random();
        logic [2:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 3'($urandom_range(0, 7));
            step(v[2], v[1], v[0], 1'b0);
            check($sformatf("random_%b", v), ref_model(v[2], v[1], v[0]));
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 3'b011 : 3'b100;
            step(v[2], v[1], v[0], 1'b0);
            check($sformatf("toggle_%b", v), ref_model(v[2], v[1], v[0]));
        end
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 3'b010 : 3'b101;
            step(v[2], v[1], v[0], 1'b0);
            check($sformatf("toggle_%b", v), ref_model(v[2], v[1], v[0]));
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(v[2], v[1], v[0], (i == 5));
            if (i == 5)
                check("midreset_101", 2'b00);
            else
                check($sformatf("midreset_seq_%b", v), ref_model(v[2], v[1], v[0]));
        end
    endtask

    task automatic test_x_prop();
        logic [2:0] xa;
        logic [2:0] xb;
        logic [2:0] xc;
        xa = {1'bx, 1'bx, 1'bx};
        xb = {1'bx, 1'bx, 1'b0};
        xc = {1'bx, 1'b0, 1'b0};
        step(xa[2], xa[1], xa[0], 1'b0);
        check("x_xxx", ref_model(bus.a, bus.b, bus.c));
        step(xb[2], xb[1], xb[0], 1'b0);
        check("x_xx0", ref_model(bus.a, bus.b, bus.c));
        step(xc[2], xc[1], xc[0], 1'b0);
        check("x_x00", ref_model(bus.a, bus.b, bus.c));
        step(1'b0, 1'b0, 1'bx, 1'b0);
        check("x_00x", ref_model(bus.a, bus.b, bus.c));
        step(1'b0, 1'bx, 1'bx, 1'b0);
        check("x_0xx", ref_model(bus.a, bus.b, bus.c));
        step(1'b0, 1'bx, 1'b0, 1'b0);
        check("x_0x0", ref_model(bus.a, bus.b, bus.c));
        // Reset must clear even with unknown operands present.
        step(1'bx, 1'bx, 1'bx, 1'b1);
        check("x_reset", 2'b00);
    endtask

    task automatic test_half_subtractor();
        logic [1:0] v;
        int         r;
        for (int i = 0; i < 4; i++) begin
            v  = 2'(i);
            hx = v[1];
            hy = v[0];
            #1;
            r = int'(v[1]) - int'(v[0]);
            total++;
            if ({hd, hbo} !== {r[0], r < 0}) begin
                bad++;
                $display("FAIL hs_%b: got d,bo=%b%b required %b%b",
                         v, hd, hbo, r[0], r < 0);
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        bus.a = 1'b0;
        bus.b = 1'b0;
        bus.c = 1'b0;
        hx    = 1'b0;
        hy    = 1'b0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_x_prop();
        test_half_subtractor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
